// File: rtl/spmv_wb_writer_if.sv
// Row-sum handshake between the SpMV core and the write-back block.
// Latency: none, this file holds wires only.
// Backpressure: the core holds a row sum until o_result_ready is seen high with i_result_valid.
// Signals: i_result_valid / i_result_row / i_result_data (core -> writer), o_result_ready (writer -> core).
interface spmv_wb_writer_if;
  logic        i_result_valid;
  logic        o_result_ready;
  logic [3:0]  i_result_row;
  logic [31:0] i_result_data;

  modport master (
    output i_result_valid,
    output i_result_row,
    output i_result_data,
    input  o_result_ready
  );

  modport slave (
    input  i_result_valid,
    input  i_result_row,
    input  i_result_data,
    output o_result_ready
  );
endinterface

// File: rtl/spmv_wb_writer.sv
// Collects 16 row sums into a 16x16-bit bank and streams them to SRAM on request.
// Latency: a row lands in the bank 1 cycle after its handshake; the write-back is 16 strobes, then a done pulse.
// Backpressure: o_result_ready is low while i_clear is high and for the whole write-back (WRITE and DONE).
//
// Ports: i_clk, i_rstn (async, active low); res (row-sum handshake, slave side); i_clear (zero the
//   bank, IDLE only); i_write_start (begin the write-back); o_write_addr / o_write_data / o_write_en /
//   o_write_done (registered SRAM write port); o_register (bank, row r at [16r+15:16r]); o_state.
// Build option: define SPMV_WB_SAT_EN to saturate 32-bit sums to int16; without it they are truncated.
module spmv_wb_writer #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  spmv_wb_writer_if.slave      res,
  input  logic                 i_clear,
  input  logic                 i_write_start,
  output logic [ADDR_W-1:0]    o_write_addr,
  output logic [15:0]          o_write_data,
  output logic                 o_write_en,
  output logic                 o_write_done,
  output logic [255:0]         o_register,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // The base is reduced to ADDR_W bits once, so every address sum wraps silently.
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t             state_q;
  // Bit 4 of the row counter marks "all 16 rows streamed".
  logic [4:0]         cnt_q;
  logic [15:0]        bank_q [16];
  logic [ADDR_W-1:0]  write_addr_q;
  logic [15:0]        write_data_q;
  logic               write_en_q;
  logic               write_done_q;

  logic               ready_d;
  logic               hs_d;
  logic [15:0]        conv_d;
  logic [ADDR_W-1:0]  addr_d;

  assign ready_d            = (state_q == ST_IDLE) && !i_clear;
  assign hs_d               = res.i_result_valid && ready_d;
  assign res.o_result_ready = ready_d;
  assign addr_d             = BASE + ADDR_W'(cnt_q[3:0]);

`ifdef SPMV_WB_SAT_EN
  always_comb begin
    conv_d = res.i_result_data[15:0];
    if ($signed(res.i_result_data) > 32'sd32767) begin
      conv_d = 16'h7FFF;
    end else if ($signed(res.i_result_data) < -32'sd32768) begin
      conv_d = 16'h8000;
    end
  end
`else
  // Upper half is simply dropped in the truncating build.
  logic unused_data_hi;
  assign unused_data_hi = ^res.i_result_data[31:16];
  assign conv_d         = res.i_result_data[15:0];
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      write_addr_q <= BASE;
      write_data_q <= 16'd0;
      write_en_q   <= 1'b0;
      write_done_q <= 1'b0;
      for (int r = 0; r < 16; r++) begin
        bank_q[r] <= 16'd0;
      end
    end else begin
      write_en_q   <= 1'b0;
      write_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Clear wins over a simultaneous row sum; ready_d is already low in that case.
          if (i_clear) begin
            for (int r = 0; r < 16; r++) begin
              bank_q[r] <= 16'd0;
            end
          end else if (hs_d) begin
            bank_q[res.i_result_row] <= conv_d;
          end
          if (i_write_start) begin
            state_q <= ST_WRITE;
            cnt_q   <= 5'd0;
          end
        end
        ST_WRITE: begin
          if (cnt_q[4]) begin
            // Row 15 went out on the previous edge: raise done while moving to DONE.
            write_done_q <= 1'b1;
            cnt_q        <= 5'd0;
            state_q      <= ST_DONE;
          end else begin
            write_en_q   <= 1'b1;
            write_addr_q <= addr_d;
            write_data_q <= bank_q[cnt_q[3:0]];
            cnt_q        <= cnt_q + 5'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_register = '0;
    for (int r = 0; r < 16; r++) begin
      o_register[16*r +: 16] = bank_q[r];
    end
  end

  assign o_write_addr = write_addr_q;
  assign o_write_data = write_data_q;
  assign o_write_en   = write_en_q;
  assign o_write_done = write_done_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_spmv_wb_writer.sv
// Directed and randomized bench for spmv_wb_writer with a row-array reference model.
// Two instances share stimulus: base 0 and base 1020 (wrap-around of the SRAM address).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_spmv_wb_writer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         clear;
  logic         start;

  logic [9:0]   addr_a, addr_b;
  logic [15:0]  data_a, data_b;
  logic         en_a, en_b, done_a, done_b;
  logic [255:0] reg_a, reg_b;
  logic [1:0]   st_a, st_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bank contents as the specification describes them.
  logic [15:0] mbank [16];

  spmv_wb_writer_if rif_a ();
  spmv_wb_writer_if rif_b ();

  assign rif_b.i_result_valid = rif_a.i_result_valid;
  assign rif_b.i_result_row   = rif_a.i_result_row;
  assign rif_b.i_result_data  = rif_a.i_result_data;

  spmv_wb_writer #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .res(rif_a), .i_clear(clear), .i_write_start(start),
    .o_write_addr(addr_a), .o_write_data(data_a), .o_write_en(en_a), .o_write_done(done_a),
    .o_register(reg_a), .o_state(st_a)
  );

  spmv_wb_writer #(.ADDR_W(10), .BASE_ADDR(1020)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .res(rif_b), .i_clear(clear), .i_write_start(start),
    .o_write_addr(addr_b), .o_write_data(data_b), .o_write_en(en_b), .o_write_done(done_b),
    .o_register(reg_b), .o_state(st_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Signed 32-bit sum to 16-bit word, from value-range rules.
  function automatic logic [15:0] conv_model(input logic [31:0] d);
    longint v;
    v = longint'($signed(d));
`ifdef SPMV_WB_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v & 64'hFFFF);
  endfunction

  function automatic logic [255:0] model_reg();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = mbank[i];
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] row, input logic [31:0] d);
    rif_a.i_result_valid = 1'b1;
    rif_a.i_result_row   = row;
    rif_a.i_result_data  = d;
    #1;
    chk("send_ready", 256'(rif_a.o_result_ready), 256'(1'b1));
    step();
    rif_a.i_result_valid = 1'b0;
    mbank[row] = conv_model(d);
    chk("send_register", reg_a, model_reg());
  endtask

  function automatic logic [31:0] rand_data();
    int unsigned mode;
    mode = $urandom_range(0, 2);
    if (mode == 0) return 32'($urandom());
    if (mode == 1) return 32'($urandom_range(0, 65535)) - 32'd32768;
    return 32'd32766 + 32'($urandom_range(0, 3)) - ((mode == 2 && $urandom_range(0, 1) == 1) ? 32'd65536 : 32'd0);
  endfunction

  // Full write-back with checks; optionally a handshake in the start cycle and
  // ignored start/clear pulses in the middle of WRITE.
  task automatic writeback(input bit with_hs, input logic [3:0] hs_row, input logic [31:0] hs_data,
                           input bit disturb);
    start = 1'b1;
    if (with_hs) begin
      rif_a.i_result_valid = 1'b1;
      rif_a.i_result_row   = hs_row;
      rif_a.i_result_data  = hs_data;
    end
    step();
    start = 1'b0;
    rif_a.i_result_valid = 1'b0;
    if (with_hs) mbank[hs_row] = conv_model(hs_data);
    chk("wb_T_state", 256'(st_a), 256'(2'b01));
    chk("wb_T_en", 256'(en_a), 256'(1'b0));
    for (int k = 0; k < 16; k++) begin
      if (disturb && k == 3) begin
        start = 1'b1;
        clear = 1'b1;
      end
      step();
      start = 1'b0;
      clear = 1'b0;
      chk($sformatf("wb_en[%0d]", k), 256'(en_a), 256'(1'b1));
      chk($sformatf("wb_addr_a[%0d]", k), 256'(addr_a), 256'(k));
      chk($sformatf("wb_addr_b[%0d]", k), 256'(addr_b), 256'((1020 + k) % 1024));
      chk($sformatf("wb_data[%0d]", k), 256'(data_a), 256'(mbank[k]));
      chk($sformatf("wb_data_b[%0d]", k), 256'(data_b), 256'(mbank[k]));
      chk($sformatf("wb_done_early[%0d]", k), 256'(done_a), 256'(1'b0));
      chk($sformatf("wb_ready[%0d]", k), 256'(rif_a.o_result_ready), 256'(1'b0));
    end
    step();
    chk("wb_T17_done", 256'(done_a), 256'(1'b1));
    chk("wb_T17_en", 256'(en_a), 256'(1'b0));
    chk("wb_T17_state", 256'(st_a), 256'(2'b10));
    chk("wb_T17_ready", 256'(rif_a.o_result_ready), 256'(1'b0));
    step();
    chk("wb_T18_state", 256'(st_a), 256'(2'b00));
    chk("wb_T18_done", 256'(done_a), 256'(1'b0));
    chk("wb_T18_ready", 256'(rif_a.o_result_ready), 256'(1'b1));
    chk("wb_register", reg_a, model_reg());
    step();
    chk("wb_no_restart", 256'(st_a), 256'(2'b00));
  endtask

`ifdef SPMV_WB_SAT_EN
  localparam logic [15:0] EXP_POS = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS = 16'h2345;
  localparam logic [15:0] EXP_NEG = 16'h0000;
`endif

  initial begin
    int en_cnt;
    int done_cnt;
    rstn  = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    rif_a.i_result_valid = 1'b0;
    rif_a.i_result_row   = 4'd0;
    rif_a.i_result_data  = 32'd0;
    for (int i = 0; i < 16; i++) mbank[i] = 16'd0;
    step();
    step();

    // Reset state.
    chk("rst_state", 256'(st_a), 256'(2'b00));
    chk("rst_register", reg_a, 256'(0));
    chk("rst_en", 256'(en_a), 256'(1'b0));
    chk("rst_done", 256'(done_a), 256'(1'b0));
    chk("rst_addr_a", 256'(addr_a), 256'(0));
    chk("rst_addr_b", 256'(addr_b), 256'(1020));
    chk("rst_data", 256'(data_a), 256'(0));
    rstn = 1'b1;
    step();
    chk("rst_ready", 256'(rif_a.o_result_ready), 256'(1'b1));

    // Rows 0..15 carry r+1.
    for (int r = 0; r < 16; r++) send(4'(r), 32'(r + 1));
    for (int r = 0; r < 16; r++) chk("seq_model", 256'(mbank[r]), 256'(r + 1));
    writeback(1'b0, 4'd0, 32'd0, 1'b0);

    // Overwrite of the same row.
    send(4'd3, 32'd5);
    send(4'd3, 32'd9);
    chk("overwrite_bits", 256'(reg_a[63:48]), 256'(16'h0009));
    writeback(1'b0, 4'd0, 32'd0, 1'b1);

    // Conversion boundaries.
    send(4'd0, 32'h0001_2345);
    chk("conv_pos", 256'(reg_a[15:0]), 256'(EXP_POS));
    send(4'd0, 32'hFFFF_0000);
    chk("conv_neg", 256'(reg_a[15:0]), 256'(EXP_NEG));
    send(4'd1, 32'hFFFF_FFFB);
    chk("conv_small_neg", 256'(reg_a[31:16]), 256'(16'hFFFB));

    // Clear beats a simultaneous result.
    clear = 1'b1;
    rif_a.i_result_valid = 1'b1;
    rif_a.i_result_row   = 4'd7;
    rif_a.i_result_data  = 32'd77;
    #1;
    chk("clear_ready", 256'(rif_a.o_result_ready), 256'(1'b0));
    step();
    clear = 1'b0;
    rif_a.i_result_valid = 1'b0;
    for (int i = 0; i < 16; i++) mbank[i] = 16'd0;
    chk("clear_register", reg_a, 256'(0));

    // Randomized rounds, each ending in a write-back with a start-cycle handshake.
    for (int round = 0; round < 3; round++) begin
      int nsend;
      nsend = int'($urandom_range(5, 30));
      for (int s = 0; s < nsend; s++) send(4'($urandom_range(0, 15)), rand_data());
      writeback(1'b1, 4'($urandom_range(0, 15)), rand_data(), round[0]);
    end

    // Reset in the middle of a write-back.
    for (int r = 0; r < 16; r++) send(4'(r), rand_data());
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("mid_en_before", 256'(en_a), 256'(1'b1));
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) mbank[i] = 16'd0;
    chk("mid_rst_en", 256'(en_a), 256'(1'b0));
    chk("mid_rst_state", 256'(st_a), 256'(2'b00));
    chk("mid_rst_register", reg_a, 256'(0));
    chk("mid_rst_done", 256'(done_a), 256'(1'b0));
    step();
    step();
    rstn = 1'b1;
    en_cnt   = 0;
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      en_cnt   += int'(en_a);
      done_cnt += int'(done_a);
    end
    chk("post_rst_strobes", 256'(en_cnt), 256'(0));
    chk("post_rst_done", 256'(done_cnt), 256'(0));
    chk("post_rst_state", 256'(st_a), 256'(2'b00));

    // Fresh start after the abort.
    send(4'd15, 32'd4242);
    writeback(1'b0, 4'd0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spmv_wb_writer.md
SPMV_WB_WRITER -- requirements
Module: spmv_wb_writer

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM address width.
REQ-002 Parameter BASE_ADDR, default 0, SRAM address of result row 0.
REQ-003 The block SHALL provide one clock and an asynchronous, active-low reset, named i_clk and i_rstn.
REQ-004 i_clk  input  1  rising-edge clock for all state.
REQ-005 i_rstn  input  1  asynchronous active-low reset.
REQ-006 i_result_valid  input  1  core presents a finished row sum.
REQ-007 o_result_ready  output  1  writer accepts a row sum this cycle.
REQ-008 i_result_row  input  4  row index, 0..15.
REQ-009 i_result_data  input  32  signed row sum from the core.
REQ-010 i_clear  input  1  zero the result bank.
REQ-011 i_write_start  input  1  start the SRAM write-back.
REQ-012 o_write_addr  output  ADDR_W  SRAM write address.
REQ-013 o_write_data  output  16  SRAM write data.
REQ-014 o_write_en  output  1  SRAM write strobe.
REQ-015 o_write_done  output  1  one-cycle pulse when write-back is complete.
REQ-016 o_register  output  256  result bank; row r occupies bits [16r+15:16r].
REQ-017 o_state  output  2  FSM state: IDLE=00, WRITE=01, DONE=10.

Function
REQ-018 The FSM SHALL have three states: IDLE, WRITE and DONE.
REQ-019 IDLE SHALL go to WRITE on i_write_start, WRITE SHALL go to DONE after row 15 is written, and DONE SHALL go to IDLE unconditionally.
REQ-020 o_result_ready SHALL be 1 only in IDLE with i_clear low (combinational).
REQ-021 A handshake (valid && ready) SHALL write the converted i_result_data into bank row i_result_row at that clock edge.
REQ-022 A later handshake to the same row SHALL overwrite the earlier value; rows never written SHALL keep their previous value.
REQ-023 i_clear in IDLE SHALL zero all 16 rows; i_clear SHALL have priority over a simultaneous result, which is not accepted.
REQ-024 i_clear outside IDLE SHALL be ignored.
REQ-025 If i_write_start is asserted in the same IDLE cycle as a handshake, the row SHALL be captured and the write-back SHALL include it.
REQ-026 If i_write_start rises at edge T, o_write_en SHALL be 1 on cycles T+1..T+16, with o_write_addr = BASE_ADDR+k and o_write_data = row k for k = 0..15.
REQ-027 o_write_done SHALL pulse on cycle T+17, and o_result_ready SHALL be 1 again at T+18.
REQ-028 In WRITE and DONE, i_write_start SHALL be ignored and o_result_ready SHALL be 0.
REQ-029 The address SHALL be computed modulo 2^ADDR_W; wrap-around past the top address SHALL be silent.
REQ-030 o_write_addr, o_write_data, o_write_en and o_write_done SHALL be registered outputs.
REQ-031 o_register SHALL reflect the bank contents one cycle after each update.

Reset
REQ-032 On i_rstn low: state = IDLE, o_register = 0, o_write_en = 0, o_write_done = 0, o_write_addr = BASE_ADDR, o_write_data = 0, and the row counter = 0.
REQ-033 Reset asserted mid-WRITE SHALL abort immediately with no further strobes; the block SHALL restart only on a fresh i_write_start.

Configuration
REQ-034 With SPMV_WB_SAT_EN defined, the 32-to-16 conversion SHALL saturate to the signed range: >32767 gives 0x7FFF and <-32768 gives 0x8000.
REQ-035 Without SPMV_WB_SAT_EN, the conversion SHALL take i_result_data[15:0] (truncation).

Verification
REQ-036 Send rows 0..15 with data = r+1, then i_write_start -> 16 strobes at addresses 0..15 with data 1..16, o_write_done at T+17.
REQ-037 Send row 3 = 5, then row 3 = 9 -> bits [63:48] = 0x0009; write-back word 3 = 0x0009.
REQ-038 Send data 0x00012345 on row 0 -> word 0x7FFF with SPMV_WB_SAT_EN, 0x2345 without; data 0xFFFF0000 -> 0x8000 with SAT, 0x0000 without.
REQ-039 Assert i_clear and i_result_valid in the same cycle -> o_result_ready = 0, o_register = 0, result dropped.
REQ-040 Assert i_rstn low at T+8 of a write-back -> o_write_en = 0 immediately, state = IDLE, o_register = 0, no o_write_done.
REQ-041 BASE_ADDR = 1020, ADDR_W = 10 -> addresses 1020..1023, then 0..11.
